encoder_4x2_serial: RTL and testbench
=====================================

ENCODER_4X2_SERIAL -- requirements
Module: encoder_4x2_serial

Interface
REQ-001: The block SHALL use one clock and a synchronous, active-high reset.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst  input  1  reset; sampled on rising edge of clk.
REQ-004: E  input  1  enable; gates acceptance of new vectors only.
REQ-005: I  input  4  request vector; multi-hot allowed.
REQ-006: in_valid  input  1  I is valid this cycle.
REQ-007: in_ready  output  1  block can accept a vector this cycle.
REQ-008: Y  output  2  binary index of current highest set bit.
REQ-009: out_valid  output  1  Y is valid.
REQ-010: out_ready  input  1  consumer accepts Y this cycle.
REQ-011: last  output  1  Y is the final code for the current vector; qualified by out_valid.
REQ-012: pending  output  4  bits of the captured vector not yet emitted.

Function
REQ-013: The FSM SHALL have two states, IDLE and SERVE.
REQ-014: in_ready SHALL equal E AND (state == IDLE); it is combinational, with no dependency on in_valid.
REQ-015: Input handshake SHALL occur when in_valid AND in_ready are high at a rising edge.
REQ-016: On input handshake with I != 0, the block SHALL load pending <= I and move to SERVE on the same edge.
REQ-017: On input handshake with I == 0, the block SHALL discard the vector, stay in IDLE and produce no output.
REQ-018: In SERVE, out_valid SHALL be 1; in IDLE, out_valid SHALL be 0.
REQ-019: Y SHALL be the index of the highest set bit of pending, with priority 3 > 2 > 1 > 0. Examples: pending 4'b1010 -> Y=3; 4'b0110 -> Y=2.
REQ-020: In IDLE, Y SHALL be 2'b00.
REQ-021: last SHALL be 1 when pending has exactly one bit set and state is SERVE; otherwise it SHALL be 0.
REQ-022: Output handshake SHALL occur when out_valid AND out_ready are high; on that edge the bit pending[Y] SHALL be cleared.
REQ-023: On an output handshake with last=1, the state SHALL return to IDLE and pending SHALL become 0.
REQ-024: While out_ready is low in SERVE, Y, pending, last and out_valid SHALL hold stable.
REQ-025: Latency SHALL be one cycle from input handshake to first out_valid.
REQ-026: A vector with k set bits SHALL produce exactly k codes in descending index order.
REQ-027: Minimum occupancy SHALL be k cycles in SERVE plus one IDLE cycle before the next acceptance; there is no back-to-back overlap.
REQ-028: Deasserting E during SERVE SHALL NOT stall or abort draining; it only blocks the next acceptance.
REQ-029: I and in_valid SHALL be ignored while in SERVE.

Reset
REQ-030: When rst=1 at an edge, the block SHALL set state=IDLE and pending=0, giving out_valid=0, Y=2'b00 and last=0; rst has priority over all handshakes.
REQ-031: in_ready SHALL be 0 while rst is high and SHALL follow REQ-014 from the first cycle after rst is released.
REQ-032: rst asserted mid-SERVE SHALL drop the remaining pending bits with no further output.

Verification
REQ-033: Single bit: E=1, I=4'b0100 with in_valid and out_ready held 1 -> one cycle later Y=2, out_valid=1, last=1; the next cycle is IDLE with in_ready=1.
REQ-034: Multi-hot: I=4'b1011, out_ready=1 -> Y sequence 3,1,0 on consecutive cycles, with last=1 only on the Y=0 cycle; pending goes 1011 -> 0011 -> 0001 -> 0000.
REQ-035: Backpressure: I=4'b1111 with out_ready=0 for 3 cycles -> Y=3 and pending=1111 held for those 3 cycles; on release the codes 3,2,1,0 follow.
REQ-036: Gating and zero: with E=0 and in_valid=1, I=4'b0001 -> in_ready=0 and no output; with E=1 and I=4'b0000 -> accepted, state stays IDLE, out_valid stays 0.
REQ-037: Reset mid-operation: I=4'b1110 accepted, one code (Y=3) consumed, then rst=1 for one cycle -> out_valid=0 and pending=0, and codes 2 and 1 are never emitted.
REQ-038: E drop during drain: I=4'b0011 accepted, then E=0 -> codes 1,0 are still emitted; in_ready stays 0 until E=1.

Source files
------------

// File: rtl/encoder_4x2_serial_if.sv
// Handshake bundle for the serial 4-to-2 priority encoder: request side (E/I/in_valid/in_ready)
// and code side (Y/out_valid/out_ready/last/pending).
interface encoder_4x2_serial_if;
  logic       E;
  logic [3:0] I;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] Y;
  logic       out_valid;
  logic       out_ready;
  logic       last;
  logic [3:0] pending;

  modport master (
    output E, I, in_valid, out_ready,
    input  in_ready, Y, out_valid, last, pending
  );

  modport slave (
    input  E, I, in_valid, out_ready,
    output in_ready, Y, out_valid, last, pending
  );
endinterface

// File: rtl/encoder_4x2_serial.sv
// Serial 4-to-2 priority encoder: captures a multi-hot vector and emits the index of each
// set bit, highest first, one code per output handshake.
module encoder_4x2_serial (
  input  logic                         clk,
  input  logic                         rst,
  encoder_4x2_serial_if.slave          bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_pending;
  logic [3:0] w_pending_nxt;
  logic       w_idle;
  logic       w_serve;
  logic       w_in_ready;
  logic [1:0] w_y;
  logic       w_last;
  logic [3:0] w_clear_mask;

  function automatic logic [1:0] f_high_index(input logic [3:0] v);
    logic [1:0] idx;
    casez (v)
      4'b1???: idx = 2'd3;
      4'b01??: idx = 2'd2;
      4'b001?: idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic f_single_bit(input logic [3:0] v);
    logic one;
    case (v)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: one = 1'b1;
      default:                            one = 1'b0;
    endcase
    return one;
  endfunction

  assign w_idle       = (r_state == ST_IDLE);
  assign w_serve      = (r_state == ST_SERVE);
  // Held low during reset so nothing is offered while the block is being cleared.
  assign w_in_ready   = bus.E & w_idle & ~rst;
  assign w_y          = w_serve ? f_high_index(r_pending) : 2'd0;
  assign w_last       = w_serve & f_single_bit(r_pending);
  assign w_clear_mask = 4'b0001 << w_y;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_serve;
  assign bus.Y         = w_y;
  assign bus.last      = w_last;
  assign bus.pending   = r_pending;

  // State and pending-vector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= 4'b0000;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Next-state: capture non-zero vectors in IDLE, retire one bit per output handshake in SERVE.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid && w_in_ready && (bus.I != 4'b0000)) begin
          w_state_nxt   = ST_SERVE;
          w_pending_nxt = bus.I;
        end else begin
          w_state_nxt   = ST_IDLE;
          w_pending_nxt = r_pending;
        end
      end
      ST_SERVE: begin
        if (bus.out_ready && w_last) begin
          w_state_nxt   = ST_IDLE;
          w_pending_nxt = 4'b0000;
        end else if (bus.out_ready) begin
          w_state_nxt   = ST_SERVE;
          w_pending_nxt = r_pending & ~w_clear_mask;
        end else begin
          w_state_nxt   = ST_SERVE;
          w_pending_nxt = r_pending;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_pending_nxt = 4'b0000;
      end
    endcase
  end

endmodule

// File: tb/tb_encoder_4x2_serial.sv
// Scoreboard bench: accepted vectors are expanded into expected code sequences; a negedge
// monitor compares the DUT outputs against the head of that queue every cycle.
module tb_encoder_4x2_serial;

  typedef struct {
    logic [1:0] y;
    logic       last;
    logic [3:0] pend;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q[$];

  logic       drv_rst;
  logic       drv_acc;
  logic [3:0] drv_vec;
  bit         started;

  encoder_4x2_serial_if ifc ();

  encoder_4x2_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each set bit becomes one code, scanned from bit 3 down to bit 0.
  task automatic push_vec(input logic [3:0] v);
    logic [3:0] rem;
    exp_t e;
    rem = v;
    for (int b = 3; b >= 0; b--) begin
      if (v[b]) begin
        e.y    = 2'(b);
        e.pend = rem;
        rem[b] = 1'b0;
        e.last = (rem == 4'b0000);
        q.push_back(e);
      end
    end
  endtask

  task automatic step(input logic e, input logic iv, input logic [3:0] vi,
                      input logic ordy, input logic r);
    logic exp_ready;
    @(posedge clk);
    if (drv_rst) q.delete();
    else if (drv_acc) push_vec(drv_vec);
    #1;
    ifc.E = e; ifc.in_valid = iv; ifc.I = vi; ifc.out_ready = ordy; rst = r;
    drv_rst = r;
    #1;
    exp_ready = e && !r && (q.size() == 0);
    chk("in_ready", int'(ifc.in_ready), int'(exp_ready));
    drv_acc = iv && exp_ready && (vi != 4'b0000);
    drv_vec = vi;
  endtask

  // Monitor: outputs must match the expected head; a handshake retires it.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      chk("out_valid", int'(ifc.out_valid), int'(q.size() != 0));
      if (q.size() != 0) begin
        e = q[0];
        chk("Y", int'(ifc.Y), int'(e.y));
        chk("last", int'(ifc.last), int'(e.last));
        chk("pending", int'(ifc.pending), int'(e.pend));
        if (ifc.out_ready && !rst) e = q.pop_front();
      end else begin
        chk("Y_idle", int'(ifc.Y), 0);
        chk("last_idle", int'(ifc.last), 0);
        chk("pending_idle", int'(ifc.pending), 0);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; started = 1'b0;
    rst = 1'b1; drv_rst = 1'b1; drv_acc = 1'b0; drv_vec = 4'b0000;
    ifc.E = 1'b0; ifc.in_valid = 1'b0; ifc.I = 4'b0000; ifc.out_ready = 1'b0;
    @(posedge clk);
    #1 started = 1'b1;
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
    // Single bit
    step(1'b1, 1'b1, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    // Multi-hot 1011
    step(1'b1, 1'b1, 4'b1011, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    // Backpressure with 1111
    step(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    // Gating and zero vector
    step(1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    // Reset mid-operation on 1110
    step(1'b1, 1'b1, 4'b1110, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    // E dropped during drain of 0011
    step(1'b1, 1'b1, 4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 60) == 0));
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    @(posedge clk);
    #2 chk("drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
